// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared types and constants for the hardwired control unit.
//                Holds the sequencer state enum, the opcode map, the ALU
//                select codes and the instruction-class enum.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

   // Control-step state. IDLE is the reset state; HALT is terminal until clear.
   typedef enum logic [3:0] {
      IDLE = 4'd0,
      T0   = 4'd1,
      T1   = 4'd2,
      T2   = 4'd3,
      T3   = 4'd4,
      T4   = 4'd5,
      T5   = 4'd6,
      T6   = 4'd7,
      T7   = 4'd8,
      HALT = 4'd9
   } state_t;

   // Instruction classes seen by the sequencer.
   typedef enum logic [2:0] {
      LD   = 3'd0,
      LDI  = 3'd1,
      ST   = 3'd2,
      RALU = 3'd3,
      IALU = 3'd4,
      BR   = 3'd5,
      NOP  = 3'd6,
      HLT  = 3'd7
   } instr_class_t;

   // Opcode map (IR[31:27]).
   localparam logic [4:0] c_OP_LD   = 5'b00000;
   localparam logic [4:0] c_OP_LDI  = 5'b00001;
   localparam logic [4:0] c_OP_ST   = 5'b00010;
   localparam logic [4:0] c_OP_ADD  = 5'b00011;
   localparam logic [4:0] c_OP_SUB  = 5'b00100;
   localparam logic [4:0] c_OP_AND  = 5'b00101;
   localparam logic [4:0] c_OP_OR   = 5'b00110;
   localparam logic [4:0] c_OP_ADDI = 5'b01100;
   localparam logic [4:0] c_OP_ANDI = 5'b01101;
   localparam logic [4:0] c_OP_ORI  = 5'b01110;
   localparam logic [4:0] c_OP_BR   = 5'b10011;
   localparam logic [4:0] c_OP_NOP  = 5'b11010;
   localparam logic [4:0] c_OP_HALT = 5'b11011;

   // ALU operation selects driven on the opcode output.
   localparam logic [4:0] c_ALU_ADD = 5'b00011;
   localparam logic [4:0] c_ALU_SUB = 5'b00100;
   localparam logic [4:0] c_ALU_AND = 5'b00101;
   localparam logic [4:0] c_ALU_OR  = 5'b00110;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/opcode_class_decode.sv
`default_nettype none
// ============================================================================
//  Module      : opcode_class_decode
//  Description : Purely combinational opcode decoder. Maps the opcode field
//                to an instruction class and the ALU select used in T4.
//  Ports       : i_op      - opcode field IR[31:27]
//                o_cls     - instruction class
//                o_alu_sel - ALU select (ADD unless the class needs another)
//  Revision    : 1.0  initial release
// ============================================================================
module opcode_class_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int OPW = 5
) (
   input  logic [OPW-1:0] i_op,
   output instr_class_t   o_cls,
   output logic [OPW-1:0] o_alu_sel
);

   always_comb begin
      o_cls     = NOP;
      o_alu_sel = c_ALU_ADD;
      case (i_op)
         c_OP_LD   : o_cls = LD;
         c_OP_LDI  : o_cls = LDI;
         c_OP_ST   : o_cls = ST;
         // Register ALU ops pass their own opcode straight through as select.
         c_OP_ADD,
         c_OP_SUB,
         c_OP_AND,
         c_OP_OR   : begin
            o_cls     = RALU;
            o_alu_sel = i_op;
         end
         c_OP_ADDI : begin
            o_cls     = IALU;
            o_alu_sel = c_ALU_ADD;
         end
         c_OP_ANDI : begin
            o_cls     = IALU;
            o_alu_sel = c_ALU_AND;
         end
         c_OP_ORI  : begin
            o_cls     = IALU;
            o_alu_sel = c_ALU_OR;
         end
         c_OP_BR   : o_cls = BR;
         c_OP_HALT : o_cls = HLT;
         // c_OP_NOP and every unassigned opcode execute as nop.
         default   : o_cls = NOP;
      endcase
   end

endmodule : opcode_class_decode
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Hardwired control unit for the single-bus DataPath. Steps
//                through T0-T7 and decodes state + opcode into strobes.
//  Ports       : clock, clear (async, active high)
//                IR      - instruction register, IR[31:27] decoded
//                CON_FF  - branch condition, used in branch T6
//                Stop    - halt request, honoured only in Done cycles
//                bus drivers, register enables, register selects,
//                IncPC/Read/Write, opcode (ALU select), Run, Done
//  Revision    : 1.0  initial release
// ============================================================================
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int OPW = 5,
   parameter int IRW = 32
) (
   input  logic           clock,
   input  logic           clear,
   input  logic [IRW-1:0] IR,
   input  logic           CON_FF,
   input  logic           Stop,
   output logic           PCout,
   output logic           Zlowout,
   output logic           MDRout,
   output logic           Rout,
   output logic           BAout,
   output logic           Cout,
   output logic           MARin,
   output logic           PCin,
   output logic           MDRin,
   output logic           IRin,
   output logic           Yin,
   output logic           ZLowIn,
   output logic           Rin,
   output logic           CONin,
   output logic           Gra,
   output logic           Grb,
   output logic           Grc,
   output logic           IncPC,
   output logic           Read,
   output logic           Write,
   output logic [OPW-1:0] opcode,
   output logic           Run,
   output logic           Done
);

   state_t         r_state;
   instr_class_t   w_cls;
   logic [OPW-1:0] w_alu_sel;
   logic           w_done;
   logic           w_unused_ir;

   // Only the opcode field matters to the sequencer.
   assign w_unused_ir = ^IR[IRW-OPW-1:0];

   opcode_class_decode #(
      .OPW (OPW)
   ) u_decode (
      .i_op      (IR[IRW-1 -: OPW]),
      .o_cls     (w_cls),
      .o_alu_sel (w_alu_sel)
   );

   // Last control step of each instruction class.
   always_comb begin
      w_done = 1'b0;
      case (r_state)
         T2      : w_done = (w_cls == NOP) || (w_cls == HLT);
         T5      : w_done = (w_cls == LDI) || (w_cls == RALU) || (w_cls == IALU);
         T6      : w_done = (w_cls == BR);
         T7      : w_done = 1'b1;
         default : w_done = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE    : r_state <= T0;
            HALT    : r_state <= HALT;
            default : begin
               if (w_done)
                  r_state <= (Stop || (w_cls == HLT)) ? HALT : T0;
               else
                  r_state <= state_t'(r_state + 4'd1);
            end
         endcase
      end
   end

   // Strobes decode from the registered state, so an async clear drops them
   // within the same cycle.
   always_comb begin
      PCout   = 1'b0;  Zlowout = 1'b0;  MDRout = 1'b0;  Rout  = 1'b0;
      BAout   = 1'b0;  Cout    = 1'b0;  MARin  = 1'b0;  PCin  = 1'b0;
      MDRin   = 1'b0;  IRin    = 1'b0;  Yin    = 1'b0;  ZLowIn = 1'b0;
      Rin     = 1'b0;  CONin   = 1'b0;  Gra    = 1'b0;  Grb   = 1'b0;
      Grc     = 1'b0;  IncPC   = 1'b0;  Read   = 1'b0;  Write = 1'b0;
      opcode  = c_ALU_ADD;
      Run     = 1'b1;
      Done    = w_done;
      case (r_state)
         IDLE : opcode = '0;
         HALT : Run = 1'b0;
         T0   : begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
         T1   : begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         T2   : begin MDRout = 1'b1; IRin = 1'b1; end
         T3   : begin
            case (w_cls)
               LD, LDI, ST : begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
               RALU, IALU  : begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               BR          : begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
               default     : ;
            endcase
         end
         T4   : begin
            opcode = w_alu_sel;
            case (w_cls)
               LD, LDI, ST, IALU : begin Cout = 1'b1; ZLowIn = 1'b1; end
               RALU              : begin Grc = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; end
               BR                : begin PCout = 1'b1; Yin = 1'b1; end
               default           : ;
            endcase
         end
         T5   : begin
            case (w_cls)
               LD, ST           : begin Zlowout = 1'b1; MARin = 1'b1; end
               LDI, RALU, IALU  : begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               BR               : begin Cout = 1'b1; ZLowIn = 1'b1; end
               default          : ;
            endcase
         end
         T6   : begin
            case (w_cls)
               LD      : begin Read = 1'b1; MDRin = 1'b1; end
               // Read stays low so MDR captures the bus, not memory.
               ST      : begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
               BR      : begin Zlowout = 1'b1; PCin = CON_FF; end
               default : ;
            endcase
         end
         T7   : begin
            case (w_cls)
               LD      : begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               ST      : Write = 1'b1;
               default : ;
            endcase
         end
         default : ;
      endcase
   end

endmodule : control_sequencer
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Self-checking bench for control_sequencer. Expected strobe
//                vectors per control step are queued as each instruction is
//                issued and compared cycle by cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

   // Packed observation vector layout (bit positions).
   localparam logic [26:0] c_M_PCOUT   = 27'd1 << 26;
   localparam logic [26:0] c_M_ZLOWOUT = 27'd1 << 25;
   localparam logic [26:0] c_M_MDROUT  = 27'd1 << 24;
   localparam logic [26:0] c_M_ROUT    = 27'd1 << 23;
   localparam logic [26:0] c_M_BAOUT   = 27'd1 << 22;
   localparam logic [26:0] c_M_COUT    = 27'd1 << 21;
   localparam logic [26:0] c_M_MARIN   = 27'd1 << 20;
   localparam logic [26:0] c_M_PCIN    = 27'd1 << 19;
   localparam logic [26:0] c_M_MDRIN   = 27'd1 << 18;
   localparam logic [26:0] c_M_IRIN    = 27'd1 << 17;
   localparam logic [26:0] c_M_YIN     = 27'd1 << 16;
   localparam logic [26:0] c_M_ZLOWIN  = 27'd1 << 15;
   localparam logic [26:0] c_M_RIN     = 27'd1 << 14;
   localparam logic [26:0] c_M_CONIN   = 27'd1 << 13;
   localparam logic [26:0] c_M_GRA     = 27'd1 << 12;
   localparam logic [26:0] c_M_GRB     = 27'd1 << 11;
   localparam logic [26:0] c_M_GRC     = 27'd1 << 10;
   localparam logic [26:0] c_M_INCPC   = 27'd1 << 9;
   localparam logic [26:0] c_M_READ    = 27'd1 << 8;
   localparam logic [26:0] c_M_WRITE   = 27'd1 << 7;
   localparam logic [26:0] c_M_RUN     = 27'd1 << 6;
   localparam logic [26:0] c_M_DONE    = 27'd1 << 5;
   localparam logic [26:0] c_M_OP      = 27'h1F;
   localparam logic [4:0]  c_ADD = 5'b00011;
   localparam logic [4:0]  c_AND = 5'b00101;
   localparam logic [4:0]  c_OR  = 5'b00110;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] IR;
   logic        CON_FF, Stop;
   logic PCout, Zlowout, MDRout, Rout, BAout, Cout;
   logic MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin, CONin;
   logic Gra, Grb, Grc, IncPC, Read, Write, Run, Done;
   logic [4:0] opcode;
   logic [26:0] w_obs;

   int n_chk  = 0;
   int n_pass = 0;
   logic [26:0] exp_q[$];

   always #5 clock = ~clock;

   control_sequencer #(.OPW(5), .IRW(32)) dut (
      .clock(clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Rout(Rout),
      .BAout(BAout), .Cout(Cout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
      .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .Rin(Rin), .CONin(CONin),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read),
      .Write(Write), .opcode(opcode), .Run(Run), .Done(Done)
   );

   assign w_obs = {PCout, Zlowout, MDRout, Rout, BAout, Cout,
                   MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin, CONin,
                   Gra, Grb, Grc, IncPC, Read, Write, Run, Done, opcode};

   task automatic chk(input string tag, input logic [26:0] obs, input logic [26:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
   endtask

   // Running step with the given strobes and ALU select.
   function automatic logic [26:0] stp(input logic [26:0] s, input logic [4:0] op);
      return s | c_M_RUN | {22'd0, op};
   endfunction

   // Queue expected vectors for one instruction and step through it.
   // stop_mode: 0 none, 1 Stop in Done cycle, 2 Stop in a non-Done cycle.
   // cut > 0 runs only the first cut cycles.
   task automatic issue(input string name, input logic [31:0] ir, input logic con,
                        input int stop_mode, input int cut);
      logic [4:0]  op;
      logic [4:0]  isel;
      logic [26:0] e;
      int n, lim;
      op = ir[31:27];
      exp_q.push_back(stp(c_M_PCOUT | c_M_MARIN | c_M_INCPC | c_M_ZLOWIN, c_ADD));
      exp_q.push_back(stp(c_M_ZLOWOUT | c_M_PCIN | c_M_READ | c_M_MDRIN, c_ADD));
      case (op)
         5'b00000, 5'b00001, 5'b00010: begin // ld, ldi, st
            exp_q.push_back(stp(c_M_MDROUT | c_M_IRIN, c_ADD));
            exp_q.push_back(stp(c_M_GRB | c_M_BAOUT | c_M_YIN, c_ADD));
            exp_q.push_back(stp(c_M_COUT | c_M_ZLOWIN, c_ADD));
            if (op == 5'b00001) begin
               exp_q.push_back(stp(c_M_ZLOWOUT | c_M_GRA | c_M_RIN | c_M_DONE, c_ADD));
            end else begin
               exp_q.push_back(stp(c_M_ZLOWOUT | c_M_MARIN, c_ADD));
               if (op == 5'b00000) begin
                  exp_q.push_back(stp(c_M_READ | c_M_MDRIN, c_ADD));
                  exp_q.push_back(stp(c_M_MDROUT | c_M_GRA | c_M_RIN | c_M_DONE, c_ADD));
               end else begin
                  exp_q.push_back(stp(c_M_GRA | c_M_ROUT | c_M_MDRIN, c_ADD));
                  exp_q.push_back(stp(c_M_WRITE | c_M_DONE, c_ADD));
               end
            end
         end
         5'b00011, 5'b00100, 5'b00101, 5'b00110: begin // register ALU
            exp_q.push_back(stp(c_M_MDROUT | c_M_IRIN, c_ADD));
            exp_q.push_back(stp(c_M_GRB | c_M_ROUT | c_M_YIN, c_ADD));
            exp_q.push_back(stp(c_M_GRC | c_M_ROUT | c_M_ZLOWIN, op));
            exp_q.push_back(stp(c_M_ZLOWOUT | c_M_GRA | c_M_RIN | c_M_DONE, c_ADD));
         end
         5'b01100, 5'b01101, 5'b01110: begin // immediate ALU
            isel = (op == 5'b01100) ? c_ADD : (op == 5'b01101) ? c_AND : c_OR;
            exp_q.push_back(stp(c_M_MDROUT | c_M_IRIN, c_ADD));
            exp_q.push_back(stp(c_M_GRB | c_M_ROUT | c_M_YIN, c_ADD));
            exp_q.push_back(stp(c_M_COUT | c_M_ZLOWIN, isel));
            exp_q.push_back(stp(c_M_ZLOWOUT | c_M_GRA | c_M_RIN | c_M_DONE, c_ADD));
         end
         5'b10011: begin // br
            exp_q.push_back(stp(c_M_MDROUT | c_M_IRIN, c_ADD));
            exp_q.push_back(stp(c_M_GRA | c_M_ROUT | c_M_CONIN, c_ADD));
            exp_q.push_back(stp(c_M_PCOUT | c_M_YIN, c_ADD));
            exp_q.push_back(stp(c_M_COUT | c_M_ZLOWIN, c_ADD));
            exp_q.push_back(stp(c_M_ZLOWOUT | (con ? c_M_PCIN : 27'd0) | c_M_DONE, c_ADD));
         end
         default: // nop, halt and unassigned opcodes finish in T2
            exp_q.push_back(stp(c_M_MDROUT | c_M_IRIN | c_M_DONE, c_ADD));
      endcase
      n   = exp_q.size();
      lim = (cut > 0) ? cut : n;
      for (int i = 0; i < lim; i++) begin
         @(negedge clock);
         IR     = ir;
         // Condition only valid in T6; the opposite value elsewhere.
         CON_FF = (i == 6) ? con : ~con;
         Stop   = ((stop_mode == 1) && (i == n - 1)) || ((stop_mode == 2) && (i == 1));
         #1;
         e = exp_q.pop_front();
         chk($sformatf("%s.T%0d", name, i), w_obs, e);
         chk($sformatf("%s.T%0d.busdrv", name, i),
             {26'd0, ($countones(w_obs[26:21]) <= 1)}, 27'd1);
      end
      exp_q.delete();
   endtask

   task automatic halt_cycles(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         Stop = 1'b0;
         #1;
         chk($sformatf("%s.h%0d", name, i), w_obs & ~c_M_OP, 27'd0);
      end
   endtask

   // Assert clear now, check the reset outputs, release one cycle later.
   task automatic pulse_clear(input string name);
      clear = 1'b1;
      #1;
      chk({name, ".clr"}, w_obs, c_M_RUN);
      @(negedge clock);
      clear = 1'b0;
      #1;
      chk({name, ".idle"}, w_obs, c_M_RUN);
   endtask

   initial begin
      clear = 1'b1; IR = 32'h0; CON_FF = 1'b0; Stop = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         #1;
         chk($sformatf("rst%0d", i), w_obs, c_M_RUN);
      end
      @(negedge clock);
      clear = 1'b0;
      #1;
      chk("idle", w_obs, c_M_RUN);

      issue("ld",    32'h01000095, 1'b0, 0, 0);
      issue("st",    32'h10880087, 1'b0, 0, 0);
      issue("add",   32'h1A9A0000, 1'b0, 0, 0);
      issue("andi",  32'h691000FF, 1'b0, 0, 0);
      issue("ldi",   32'h08000000, 1'b0, 0, 0);
      issue("sub",   32'h20000000, 1'b0, 0, 0);
      issue("or",    32'h30000000, 1'b0, 0, 0);
      issue("addi",  32'h60000000, 1'b0, 0, 0);
      issue("ori",   32'h70000000, 1'b0, 0, 0);
      issue("br0",   32'h98000023, 1'b0, 0, 0);
      issue("br1",   32'h98000023, 1'b1, 0, 0);
      issue("nop",   32'hD0000000, 1'b0, 0, 0);
      issue("undef", 32'hF8000000, 1'b0, 0, 0);
      issue("nopst", 32'hD0000000, 1'b0, 2, 0);   // Stop outside Done: ignored
      issue("ldcut", 32'h01000095, 1'b0, 0, 5);   // stop in T4
      pulse_clear("abort");
      issue("add2",  32'h1A9A0000, 1'b0, 0, 0);
      issue("stopq", 32'hD0000000, 1'b0, 1, 0);   // Stop in Done -> HALT
      halt_cycles("stophalt", 4);
      @(negedge clock);
      pulse_clear("rel");
      issue("halt",  32'hD8000000, 1'b0, 0, 0);
      halt_cycles("halt", 20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_control_sequencer
`default_nettype wire
